des_key_schedule: RTL and testbench



---
 rtl/des_key_schedule_if.sv | 23 ++
 rtl/des_key_schedule.sv | 134 +++++++++++++
 tb/tb_des_key_schedule.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/des_key_schedule_if.sv
// Subkey request/delivery bundle between the key schedule and its consumer.
// The master drives requests and readiness; the slave returns subkeys.
interface des_key_schedule_if;
    logic        start;
    logic [63:0] key;
    logic        decrypt;
    logic [47:0] subkey;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [3:0]  round_idx;
    logic        busy;
    logic        done;

    modport master (
        output start, key, decrypt, subkey_ready,
        input  subkey, subkey_valid, round_idx, busy, done
    );

    modport slave (
        input  start, key, decrypt, subkey_ready,
        output subkey, subkey_valid, round_idx, busy, done
    );
endinterface

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: one 48-bit subkey per handshake,
// K1..K16 for encrypt or K16..K1 for decrypt.
module des_key_schedule (
    input  logic              clk,
    input  logic              rst,
    des_key_schedule_if.slave bus
);

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] o;
        o = '0;
        for (int i = 0; i < 56; i++) o[55-i] = k[64-PC1[i]];
        return o;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] o;
        o = '0;
        for (int i = 0; i < 48; i++) o[47-i] = cd[56-PC2[i]];
        return o;
    endfunction

    function automatic logic [27:0] rot(
        input logic [27:0] x,
        input logic        right,
        input logic        one
    );
        logic [27:0] o;
        unique case ({right, one})
            2'b00:   o = {x[25:0], x[27:26]};
            2'b01:   o = {x[26:0], x[27]};
            2'b10:   o = {x[1:0], x[27:2]};
            default: o = {x[0], x[27:1]};
        endcase
        return o;
    endfunction

    state_t      state;
    logic [27:0] c_q;
    logic [27:0] d_q;
    logic [3:0]  round_q;
    logic        mode_q;
    logic        busy_q;
    logic        done_q;

    logic [55:0] cd_key;
    logic [27:0] c_nxt;
    logic [27:0] d_nxt;
    logic        one;
    logic        unused_parity;

    assign cd_key = pc1(bus.key);
    assign unused_parity = ^{bus.key[56], bus.key[48], bus.key[40],
                             bus.key[32], bus.key[24], bus.key[16],
                             bus.key[8], bus.key[0]};

    // Single-bit steps fall on the same round indices in both directions.
    assign one = (round_q == 4'd0) || (round_q == 4'd7) ||
                 (round_q == 4'd14);
    assign c_nxt = rot(c_q, mode_q, one);
    assign d_nxt = rot(d_q, mode_q, one);

    assign bus.subkey       = pc2({c_q, d_q});
    assign bus.subkey_valid = busy_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.round_idx    = round_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        // Decrypt starts from C16/D16, which equal C0/D0.
                        c_q     <= bus.decrypt ? cd_key[55:28]
                                   : rot(cd_key[55:28], 1'b0, 1'b1);
                        d_q     <= bus.decrypt ? cd_key[27:0]
                                   : rot(cd_key[27:0], 1'b0, 1'b1);
                        mode_q  <= bus.decrypt;
                        round_q <= 4'd0;
                        busy_q  <= 1'b1;
                        state   <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (bus.subkey_ready) begin
                        if (round_q == 4'd15) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            round_q <= round_q + 4'd1;
                            c_q     <= c_nxt;
                            d_q     <= d_nxt;
                        end
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_des_key_schedule.sv
// Bench for des_key_schedule: FIPS vectors, stalls, resets and
// randomized keys against a cumulative-shift reference model.
module tb_des_key_schedule;

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2,
                                   1, 2, 2, 2, 2, 2, 2, 1};
    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;

    logic clk;
    logic rst;
    des_key_schedule_if bus ();

    des_key_schedule dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [47:0] got [16];
    int seq_bad;
    int done_cyc;

    // Subkey for round r (1..16) from total left rotation of C0/D0.
    function automatic logic [47:0] ref_sub(input logic [63:0] k, input int r);
        logic [27:0] c, d;
        logic [55:0] cc, dd, cd;
        logic [47:0] o;
        int tot;
        for (int i = 0; i < 28; i++) begin
            c[27-i] = k[64-PC1_T[i]];
            d[27-i] = k[64-PC1_T[28+i]];
        end
        tot = 0;
        for (int j = 0; j < r; j++) tot += SHIFTS[j];
        tot = tot % 28;
        cc = {c, c};
        dd = {d, d};
        c = cc[55-tot -: 28];
        d = dd[55-tot -: 28];
        cd = {c, d};
        for (int i = 0; i < 48; i++) o[47-i] = cd[56-PC2_T[i]];
        return o;
    endfunction

    function automatic logic [47:0] exp_sub(input logic [63:0] k,
                                            input bit dec, input int i);
        return dec ? ref_sub(k, 16 - i) : ref_sub(k, i + 1);
    endfunction

    function automatic int seq_errs(input logic [63:0] k, input bit dec);
        int n = 0;
        for (int i = 0; i < 16; i++)
            if (got[i] !== exp_sub(k, dec, i)) n++;
        return n;
    endfunction

    task automatic do_start(input logic [63:0] k, input bit dec);
        @(negedge clk);
        bus.start = 1'b1;
        bus.key = k;
        bus.decrypt = dec;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Consumer: called at the negedge of the first cycle after a load.
    task automatic collect(input bit rnd, input int stall_at,
                           input int stall_n, input bit disturb);
        logic [47:0] last_key;
        bit last_rdy;
        bit hold;
        int exp_idx;
        int stalled;
        seq_bad = 0;
        done_cyc = -1;
        exp_idx = 0;
        stalled = 0;
        last_rdy = 1'b1;
        last_key = '0;
        for (int i = 0; i < 16; i++) got[i] = '0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            if (bus.done === 1'b1) begin
                if (bus.subkey_valid !== 1'b0 || bus.busy !== 1'b0) seq_bad++;
                if (exp_idx != 16) seq_bad++;
                done_cyc = cyc;
                if (disturb) bus.start = 1'b0;
                bus.subkey_ready = 1'b1;
                break;
            end
            if (bus.subkey_valid !== 1'b1 || bus.busy !== 1'b1) seq_bad++;
            if (bus.round_idx !== exp_idx[3:0]) seq_bad++;
            if (!last_rdy && bus.subkey !== last_key) seq_bad++;
            hold = 1'b0;
            if (stall_n > 0 && bus.round_idx == 4'(stall_at) &&
                stalled < stall_n) begin
                hold = 1'b1;
                stalled++;
            end else if (rnd && $urandom_range(0, 2) == 0) begin
                hold = 1'b1;
            end
            if (!hold) begin
                if (exp_idx < 16) got[exp_idx] = bus.subkey;
                exp_idx++;
            end
            bus.subkey_ready = !hold;
            last_rdy = !hold;
            last_key = bus.subkey;
            if (disturb) begin
                bus.start = 1'($urandom_range(0, 1));
                bus.key = {$urandom, $urandom};
                bus.decrypt = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.key = '0;
        bus.decrypt = 1'b0;
        bus.subkey_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.subkey_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: valid=%b busy=%b done=%b want 000",
                     bus.subkey_valid, bus.busy, bus.done);
        end
        checks++;
        if (bus.round_idx !== 4'd0 || bus.subkey !== 48'd0) begin
            failures++;
            $display("FAIL reset_data: round=%0d subkey=%h want 0/0",
                     bus.round_idx, bus.subkey);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.subkey_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: busy=%b valid=%b want 0",
                     bus.busy, bus.subkey_valid);
        end
    endtask

    task automatic test_encrypt;
        int n;
        do_start(KEY_A, 1'b0);
        collect(1'b0, 0, 0, 1'b0);
        checks++;
        if (got[0] !== 48'h1B02EFFC7072) begin
            failures++;
            $display("FAIL enc_k1: got %h want 1b02effc7072", got[0]);
        end
        checks++;
        if (got[1] !== 48'h79AED9DBC9E5) begin
            failures++;
            $display("FAIL enc_k2: got %h want 79aed9dbc9e5", got[1]);
        end
        checks++;
        if (got[15] !== 48'hCB3D8B0E17F5) begin
            failures++;
            $display("FAIL enc_k16: got %h want cb3d8b0e17f5", got[15]);
        end
        n = seq_errs(KEY_A, 1'b0);
        checks++;
        if (n != 0 || seq_bad != 0) begin
            failures++;
            $display("FAIL enc_seq: %0d wrong subkeys, %0d protocol errs, want 0",
                     n, seq_bad);
        end
        checks++;
        if (done_cyc != 17) begin
            failures++;
            $display("FAIL enc_done_time: got cycle %0d want 17", done_cyc);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL done_width: done=%b busy=%b want 0 0", bus.done, bus.busy);
        end
    endtask

    task automatic test_decrypt;
        int n;
        do_start(KEY_A, 1'b1);
        collect(1'b0, 0, 0, 1'b0);
        checks++;
        if (got[0] !== 48'hCB3D8B0E17F5 || got[14] !== 48'h79AED9DBC9E5 ||
            got[15] !== 48'h1B02EFFC7072) begin
            failures++;
            $display("FAIL dec_vectors: got %h %h %h want cb3d8b0e17f5 79aed9dbc9e5 1b02effc7072",
                     got[0], got[14], got[15]);
        end
        n = 0;
        for (int i = 0; i < 16; i++)
            if (got[i] !== ref_sub(KEY_A, 16 - i)) n++;
        checks++;
        if (n != 0 || seq_bad != 0) begin
            failures++;
            $display("FAIL dec_seq: %0d wrong subkeys, %0d protocol errs, want 0",
                     n, seq_bad);
        end
        checks++;
        if (done_cyc != 17) begin
            failures++;
            $display("FAIL dec_done_time: got cycle %0d want 17", done_cyc);
        end
    endtask

    task automatic test_stall;
        int n;
        do_start(KEY_A, 1'b0);
        collect(1'b0, 7, 5, 1'b0);
        n = seq_errs(KEY_A, 1'b0);
        checks++;
        if (n != 0 || seq_bad != 0) begin
            failures++;
            $display("FAIL stall_seq: %0d wrong subkeys, %0d protocol errs, want 0",
                     n, seq_bad);
        end
        checks++;
        if (done_cyc != 22) begin
            failures++;
            $display("FAIL stall_done_time: got cycle %0d want 22", done_cyc);
        end
    endtask

    task automatic test_parity_ignore;
        int n;
        do_start(KEY_A ^ 64'h0101010101010101, 1'b0);
        collect(1'b0, 0, 0, 1'b0);
        n = seq_errs(KEY_A, 1'b0);
        checks++;
        if (n != 0 || seq_bad != 0) begin
            failures++;
            $display("FAIL parity_seq: %0d wrong subkeys, %0d protocol errs, want 0",
                     n, seq_bad);
        end
        do_start(KEY_A, 1'b1);
        collect(1'b0, 0, 0, 1'b1);
        n = seq_errs(KEY_A, 1'b1);
        checks++;
        if (n != 0 || seq_bad != 0 || done_cyc != 17) begin
            failures++;
            $display("FAIL disturb_seq: %0d wrong, %0d errs, done at %0d want 0 0 17",
                     n, seq_bad, done_cyc);
        end
    endtask

    task automatic test_reset_mid;
        logic [63:0] k2;
        int n;
        int waited;
        bit saw;
        k2 = {$urandom, $urandom};
        do_start(KEY_A, 1'b0);
        waited = 0;
        while (bus.round_idx !== 4'd9 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (bus.round_idx !== 4'd9) begin
            failures++;
            $display("FAIL reach_round9: round=%0d want 9", bus.round_idx);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.subkey_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.round_idx !== 4'd0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL async_abort: valid=%b busy=%b round=%0d done=%b want 0 0 0 0",
                     bus.subkey_valid, bus.busy, bus.round_idx, bus.done);
        end
        @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.subkey_valid === 1'b1) saw = 1'b1;
        end
        checks++;
        if (saw) begin
            failures++;
            $display("FAIL no_done_after_abort: saw=1 want 0");
        end
        do_start(k2, 1'b1);
        collect(1'b0, 0, 0, 1'b0);
        n = seq_errs(k2, 1'b1);
        checks++;
        if (n != 0 || seq_bad != 0 || done_cyc != 17) begin
            failures++;
            $display("FAIL restart_seq: %0d wrong, %0d errs, done at %0d want 0 0 17",
                     n, seq_bad, done_cyc);
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] k1, k2;
        int n1, n2, b1, d1;
        k1 = {$urandom, $urandom};
        k2 = {$urandom, $urandom};
        @(negedge clk);
        bus.start = 1'b1;
        bus.key = k1;
        bus.decrypt = 1'b0;
        @(negedge clk);
        collect(1'b0, 0, 0, 1'b0);
        n1 = seq_errs(k1, 1'b0);
        b1 = seq_bad;
        d1 = done_cyc;
        bus.key = k2;
        bus.decrypt = 1'b1;
        @(negedge clk);
        collect(1'b0, 0, 0, 1'b0);
        bus.start = 1'b0;
        n2 = seq_errs(k2, 1'b1);
        checks++;
        if (n1 != 0 || b1 != 0 || d1 != 17) begin
            failures++;
            $display("FAIL b2b_first: %0d wrong, %0d errs, done at %0d want 0 0 17",
                     n1, b1, d1);
        end
        checks++;
        if (n2 != 0 || seq_bad != 0 || done_cyc != 17) begin
            failures++;
            $display("FAIL b2b_second: %0d wrong, %0d errs, done at %0d want 0 0 17",
                     n2, seq_bad, done_cyc);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle: busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_random;
        logic [63:0] k;
        bit dec;
        int n;
        for (int t = 0; t < 8; t++) begin
            k = {$urandom, $urandom};
            dec = 1'($urandom_range(0, 1));
            do_start(k, dec);
            collect(1'b1, 0, 0, 1'b0);
            n = seq_errs(k, dec);
            checks++;
            if (n != 0 || seq_bad != 0 || done_cyc < 17) begin
                failures++;
                $display("FAIL random_%0d: key=%h dec=%b %0d wrong, %0d errs, done at %0d",
                         t, k, dec, n, seq_bad, done_cyc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_encrypt();
        test_decrypt();
        test_stall();
        test_parity_ignore();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
